// File: rtl/imem_boot_ctrl_pkg.sv
// rtl/imem_boot_ctrl_pkg.sv - shared states, instruction words and opcodes for the imem boot loader
package imem_boot_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_RST_HOLD,
        ST_RUN,
        ST_DONE
    } boot_state_t;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [31:0] HALT_WORD = 32'h0000_006f;

    // Major opcodes decoded by cpu_top
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic is_halt(input logic [31:0] instr);
        return instr == HALT_WORD;
    endfunction

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// rtl/imem_boot_ctrl_if.sv - program word stream in, imem write port out
interface imem_boot_ctrl_if #(
    parameter int ADDR_W = 6
) ();
    logic              load_valid;
    logic              load_ready;
    logic [31:0]       load_data;
    logic              load_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    modport master (
        input  load_valid, load_data, load_last,
        output load_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        output load_valid, load_data, load_last,
        input  load_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_ctrl_run_watchdog.sv
// rtl/imem_boot_ctrl_run_watchdog.sv - RUN cycle counter with budget and halt detection
module boot_run_watchdog
    import imem_boot_ctrl_pkg::*;
#(
    parameter int RUN_CYCLES = 70
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] cpu_instr,
    output logic [15:0] run_cycles,
    output logic        halt_hit,
    output logic        budget_hit
);
    logic [15:0] cnt_inc;

    // cnt_inc is the count including the current RUN cycle
    always_comb begin
        cnt_inc = (run_cycles == 16'hFFFF) ? run_cycles : run_cycles + 16'd1;
    end

    assign halt_hit   = en && is_halt(cpu_instr);
    assign budget_hit = en && (cnt_inc == 16'(RUN_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cycles <= 16'd0;
        end else if (clr) begin
            run_cycles <= 16'd0;
        end else if (en) begin
            run_cycles <= cnt_inc;
        end
    end
endmodule

// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - loads imem from a word stream, NOP-fills, then runs the core under a cycle budget
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = 6,
    parameter int RST_HOLD   = 2,
    parameter int RUN_CYCLES = 70
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    imem_boot_ctrl_if.master    bus,
    output logic                cpu_rst,
    input  logic [31:0]         cpu_instr,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [ADDR_W:0]     words_loaded,
    output logic [15:0]         run_cycles
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [15:0]       HOLD_LAST = 16'(RST_HOLD - 1);

    boot_state_t       state;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       hold_cnt;
    logic              accept;
    logic              start_ok;
    logic              halt_hit;
    logic              budget_hit;

    assign accept   = (state == ST_LOAD) && bus.load_valid;
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

    // Stream writes go straight through to imem in the accept cycle
    always_comb begin
        bus.load_ready = (state == ST_LOAD);
        bus.imem_we    = accept || (state == ST_FILL);
        bus.imem_waddr = addr;
        bus.imem_wdata = 32'd0;
        if (state == ST_FILL) begin
            bus.imem_wdata = NOP_WORD;
        end else if (accept) begin
            bus.imem_wdata = bus.load_data;
        end
    end

    boot_run_watchdog #(.RUN_CYCLES(RUN_CYCLES)) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok),
        .en         (state == ST_RUN),
        .cpu_instr  (cpu_instr),
        .run_cycles (run_cycles),
        .halt_hit   (halt_hit),
        .budget_hit (budget_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            addr         <= '0;
            hold_cnt     <= 16'd0;
            words_loaded <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            cpu_rst      <= 1'b1;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state        <= ST_LOAD;
                        addr         <= '0;
                        words_loaded <= '0;
                        done         <= 1'b0;
                        timeout      <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        addr         <= addr + ADDR_W'(1);
                        words_loaded <= words_loaded + (ADDR_W+1)'(1);
                        // A full imem needs no fill, whatever load_last says
                        if (addr == LAST_ADDR) begin
                            state    <= ST_RST_HOLD;
                            hold_cnt <= 16'd0;
                        end else if (bus.load_last) begin
                            state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    addr <= addr + ADDR_W'(1);
                    if (addr == LAST_ADDR) begin
                        state    <= ST_RST_HOLD;
                        hold_cnt <= 16'd0;
                    end
                end
                ST_RST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state   <= ST_RUN;
                        cpu_rst <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                ST_RUN: begin
                    if (halt_hit || budget_hit) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        timeout <= !halt_hit;
                        cpu_rst <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cpu_rst <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb/tb_imem_boot_ctrl.sv - randomized self-checking bench for imem_boot_ctrl
module tb_imem_boot_ctrl;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0000_006f;
    localparam int DEPTH  = 64;
    localparam int HOLD   = 2;
    localparam int BUDGET = 70;

    logic        clk = 1'b0;
    logic        rst, start, cpu_rst, busy, done, timeout;
    logic [31:0] cpu_instr;
    logic [6:0]  words_loaded;
    logic [15:0] run_cycles;

    imem_boot_ctrl_if #(.ADDR_W(6)) bus ();

    imem_boot_ctrl #(.IMEM_DEPTH(DEPTH), .ADDR_W(6), .RST_HOLD(HOLD), .RUN_CYCLES(BUDGET)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .cpu_rst      (cpu_rst),
        .cpu_instr    (cpu_instr),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .words_loaded (words_loaded),
        .run_cycles   (run_cycles)
    );

    always #5 clk = ~clk;

    int checks, failures;
    int cyc = 0;
    int last_we_cyc, first_run_cyc, n_run;
    logic [31:0] prog [DEPTH];
    logic [5:0]  wlog_a [$];
    logic [31:0] wlog_d [$];
    int          wlog_c [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wlog_a.push_back(bus.imem_waddr);
            wlog_d.push_back(bus.imem_wdata);
            wlog_c.push_back(cyc);
            last_we_cyc = cyc;
        end
    end

    function automatic logic [31:0] nonhalt();
        logic [31:0] w = $urandom;
        return (w == HALT) ? NOP : w;
    endfunction

    // Expected imem image: program words first, NOPs up to the top, written once each in address order
    function automatic int log_errors(input int n);
        int e = 0;
        if (wlog_a.size() != DEPTH) return 100 + wlog_a.size();
        for (int i = 0; i < DEPTH; i++)
            if (wlog_a[i] !== 6'(i) || wlog_d[i] !== ((i < n) ? prog[i] : NOP)) e++;
        return e;
    endfunction

    function automatic int exp_run(input int halt_at);
        return (halt_at >= 1 && halt_at <= BUDGET) ? halt_at : BUDGET;
    endfunction

    task automatic clear_log();
        wlog_a.delete(); wlog_d.delete(); wlog_c.delete();
        last_we_cyc = -1;
    endtask

    task automatic fill_prog();
        for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic drive_load(input int n, input bit use_last, input int gap_pct, output int acc);
        int  guard = 0;
        bit  v;
        acc = 0;
        while (acc < n && guard < 1000) begin
            v = (gap_pct == 0) || (int'($urandom_range(99)) >= gap_pct);
            bus.load_valid = v;
            bus.load_data  = prog[acc];
            bus.load_last  = use_last && (acc == n - 1);
            @(negedge clk);
            if (v && bus.load_ready === 1'b1) acc++;
            @(posedge clk); #1;
            guard++;
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.load_data  = 32'd0;
    endtask

    task automatic run_phase(input int halt_at);
        int k = 0;
        bit seen = 0;
        first_run_cyc = -1;
        for (int g = 0; g < 400; g++) begin
            @(posedge clk); #1;
            if (cpu_rst === 1'b0) begin
                if (!seen) first_run_cyc = cyc;
                seen = 1;
                k++;
                cpu_instr = (k == halt_at) ? HALT : nonhalt();
            end else if (seen) begin
                break;
            end
        end
        cpu_instr = nonhalt();
        n_run = k;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL rst_load_ready got=%0d exp=0", bus.load_ready); end
        checks++; if (bus.imem_we !== 1'b0) begin failures++; $display("FAIL rst_imem_we got=%0d exp=0", bus.imem_we); end
        checks++; if (bus.imem_waddr !== 6'd0) begin failures++; $display("FAIL rst_waddr got=%0d exp=0", bus.imem_waddr); end
        checks++; if (bus.imem_wdata !== 32'd0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", bus.imem_wdata); end
        checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL rst_cpu_rst got=%0d exp=1", cpu_rst); end
        checks++; if ({busy, done, timeout} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {busy, done, timeout}); end
        checks++; if (words_loaded !== 7'd0 || run_cycles !== 16'd0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", words_loaded, run_cycles); end
        rst = 1'b0;
    endtask

    task automatic test_load_fill();
        int acc;
        prog[0] = 32'h00a00093; prog[1] = 32'h00300113; prog[2] = 32'h002081b3;
        clear_log();
        do_start();
        drive_load(3, 1'b1, 0, acc);
        run_phase(1);
        checks++; if (acc != 3) begin failures++; $display("FAIL lf_accepted got=%0d exp=3", acc); end
        checks++; if (log_errors(3) != 0) begin failures++; $display("FAIL lf_image got=%0d bad writes exp=0", log_errors(3)); end
        checks++; if (wlog_c.size() != DEPTH || wlog_c[DEPTH-1] - wlog_c[0] != DEPTH - 1) begin failures++; $display("FAIL lf_contiguous got=%0d writes exp=64 back-to-back", wlog_c.size()); end
        checks++; if (words_loaded !== 7'd3) begin failures++; $display("FAIL lf_words got=%0d exp=3", words_loaded); end
        checks++; if (first_run_cyc - last_we_cyc != HOLD + 1) begin failures++; $display("FAIL lf_hold got=%0d exp=%0d", first_run_cyc - last_we_cyc, HOLD + 1); end
    endtask

    task automatic test_backpressure();
        bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int acc = 0;
        fill_prog();
        clear_log();
        do_start();
        for (int c = 0; c < 5; c++) begin
            bus.load_valid = pat[c];
            bus.load_data  = prog[acc];
            bus.load_last  = (acc == 2);
            @(negedge clk);
            checks++; if (bus.imem_we !== pat[c]) begin failures++; $display("FAIL bp_we_c%0d got=%0d exp=%0d", c, bus.imem_we, pat[c]); end
            if (pat[c]) begin
                checks++; if (bus.imem_waddr !== 6'(acc) || bus.imem_wdata !== prog[acc]) begin failures++; $display("FAIL bp_write_c%0d got=%0d:%h exp=%0d:%h", c, bus.imem_waddr, bus.imem_wdata, acc, prog[acc]); end
                acc++;
            end
            @(posedge clk); #1;
        end
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        run_phase(2);
        checks++; if (log_errors(3) != 0) begin failures++; $display("FAIL bp_image got=%0d bad writes exp=0", log_errors(3)); end
    endtask

    task automatic test_halt();
        int acc;
        prog[0] = 32'h00a00093; prog[1] = 32'h00300113; prog[2] = 32'h002081b3;
        do_start();
        drive_load(3, 1'b1, 40, acc);
        run_phase(5);
        checks++; if (done !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL halt_flags got=%b%b exp=10", done, timeout); end
        checks++; if (run_cycles !== 16'd5 || n_run != 5) begin failures++; $display("FAIL halt_cycles got=%0d/%0d exp=5", run_cycles, n_run); end
        checks++; if (cpu_rst !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL halt_cpu_rst got=%b%b exp=10", cpu_rst, busy); end
    endtask

    task automatic test_timeout();
        int acc;
        fill_prog();
        do_start();
        drive_load(7, 1'b1, 0, acc);
        run_phase(0);
        checks++; if (done !== 1'b1 || timeout !== 1'b1) begin failures++; $display("FAIL to_flags got=%b%b exp=11", done, timeout); end
        checks++; if (run_cycles !== 16'(BUDGET) || n_run != BUDGET) begin failures++; $display("FAIL to_cycles got=%0d/%0d exp=%0d", run_cycles, n_run, BUDGET); end
    endtask

    task automatic test_full_load();
        int acc;
        int h = $urandom_range(1, 20);
        fill_prog();
        clear_log();
        do_start();
        drive_load(DEPTH, 1'b0, 20, acc);
        checks++; if (acc != DEPTH) begin failures++; $display("FAIL full_accepted got=%0d exp=64", acc); end
        checks++; if (bus.load_ready !== 1'b0 || words_loaded !== 7'd64) begin failures++; $display("FAIL full_after got=%0d/%0d exp=0/64", bus.load_ready, words_loaded); end
        bus.load_valid = 1'b1;
        bus.load_data  = $urandom;
        run_phase(h);
        bus.load_valid = 1'b0;
        checks++; if (log_errors(DEPTH) != 0) begin failures++; $display("FAIL full_image got=%0d bad writes exp=0", log_errors(DEPTH)); end
        checks++; if (first_run_cyc - last_we_cyc != HOLD + 1) begin failures++; $display("FAIL full_hold got=%0d exp=%0d", first_run_cyc - last_we_cyc, HOLD + 1); end
        checks++; if (run_cycles !== 16'(h) || words_loaded !== 7'd64) begin failures++; $display("FAIL full_end got=%0d/%0d exp=%0d/64", run_cycles, words_loaded, h); end
    endtask

    task automatic test_rst_mid_load();
        int acc;
        fill_prog();
        do_start();
        drive_load(10, 1'b0, 0, acc);
        rst = 1'b1;
        #1;
        checks++; if (bus.load_ready !== 1'b0 || cpu_rst !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst_ctrl got=%b%b%b exp=010", bus.load_ready, cpu_rst, busy); end
        checks++; if (words_loaded !== 7'd0 || bus.imem_waddr !== 6'd0) begin failures++; $display("FAIL mid_rst_counters got=%0d/%0d exp=0/0", words_loaded, bus.imem_waddr); end
        @(posedge clk); #1 rst = 1'b0;
        fill_prog();
        clear_log();
        do_start();
        drive_load(4, 1'b1, 30, acc);
        run_phase(3);
        checks++; if (log_errors(4) != 0) begin failures++; $display("FAIL mid_reload got=%0d bad writes exp=0", log_errors(4)); end
        checks++; if (words_loaded !== 7'd4) begin failures++; $display("FAIL mid_words got=%0d exp=4", words_loaded); end
    endtask

    task automatic test_back_to_back();
        int acc;
        fill_prog();
        clear_log();
        do_start();
        checks++; if ({done, timeout, busy, bus.load_ready} !== 4'b0011) begin failures++; $display("FAIL b2b_restart got=%b exp=0011", {done, timeout, busy, bus.load_ready}); end
        checks++; if (run_cycles !== 16'd0 || words_loaded !== 7'd0) begin failures++; $display("FAIL b2b_cleared got=%0d/%0d exp=0/0", run_cycles, words_loaded); end
        drive_load(2, 1'b1, 0, acc);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        run_phase(1);
        checks++; if (log_errors(2) != 0) begin failures++; $display("FAIL b2b_start_ignored got=%0d bad writes exp=0", log_errors(2)); end
        checks++; if (done !== 1'b1 || run_cycles !== 16'd1) begin failures++; $display("FAIL b2b_done got=%0d/%0d exp=1/1", done, run_cycles); end
    endtask

    task automatic test_random();
        int acc, n, gap, h;
        bit lst;
        for (int it = 0; it < 6; it++) begin
            n   = (it == 0) ? DEPTH : $urandom_range(1, DEPTH);
            lst = (n == DEPTH) ? 1'($urandom_range(1)) : 1'b1;
            gap = $urandom_range(0, 60);
            h   = (it == 1) ? BUDGET : $urandom_range(0, 80);
            fill_prog();
            clear_log();
            do_start();
            drive_load(n, lst, gap, acc);
            run_phase(h);
            checks++; if (acc != n || words_loaded !== 7'(n)) begin failures++; $display("FAIL rnd%0d_words got=%0d/%0d exp=%0d", it, acc, words_loaded, n); end
            checks++; if (log_errors(n) != 0) begin failures++; $display("FAIL rnd%0d_image got=%0d bad writes exp=0", it, log_errors(n)); end
            checks++; if (first_run_cyc - last_we_cyc != HOLD + 1) begin failures++; $display("FAIL rnd%0d_hold got=%0d exp=%0d", it, first_run_cyc - last_we_cyc, HOLD + 1); end
            checks++; if (run_cycles !== 16'(exp_run(h)) || n_run != exp_run(h)) begin failures++; $display("FAIL rnd%0d_cycles got=%0d/%0d exp=%0d", it, run_cycles, n_run, exp_run(h)); end
            checks++; if (done !== 1'b1 || timeout !== !(h >= 1 && h <= BUDGET)) begin failures++; $display("FAIL rnd%0d_flags got=%b%b exp=1%b", it, done, timeout, !(h >= 1 && h <= BUDGET)); end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; cpu_instr = 32'd0;
        bus.load_valid = 1'b0; bus.load_data = 32'd0; bus.load_last = 1'b0;
        last_we_cyc = -1; first_run_cyc = -1; n_run = 0;
        test_reset();
        test_load_fill();
        test_backpressure();
        test_halt();
        test_timeout();
        test_full_load();
        test_rst_mid_load();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Boot sequencer for the single-cycle RV32I core (cpu_top).
- Holds the core in reset while accepting program words over a valid/ready stream and writing them into instruction memory.
- Pads the rest of imem with NOPs, releases core reset, then supervises execution until a halt instruction is fetched or a cycle budget expires.
- Replaces hierarchical imem pokes in benches and serves as the on-chip program loader.

Parameters:
- IMEM_DEPTH, 64, number of 32-bit imem words.
- ADDR_W, 6, imem word-address width (log2 IMEM_DEPTH).
- RST_HOLD, 2, cycles core reset stays high after imem is written.
- RUN_CYCLES, 70, maximum RUN cycles before timeout (1..65535).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load/run session (honoured in IDLE or DONE only).
- load_valid  in  1  program word valid.
- load_ready  out  1  controller accepts a word this cycle.
- load_data  in  32  program word.
- load_last  in  1  current word is the final program word.
- imem_we  out  1  imem write strobe.
- imem_waddr  out  ADDR_W  imem word address.
- imem_wdata  out  32  imem write data.
- cpu_rst  out  1  reset to cpu_top, active-high.
- cpu_instr  in  32  instruction currently fetched by the core.
- busy  out  1  session in progress (LOAD/FILL/RST_HOLD/RUN).
- done  out  1  session finished (sticky until next start or rst).
- timeout  out  1  session ended by cycle budget (valid when done=1).
- words_loaded  out  ADDR_W+1  words accepted from the stream.
- run_cycles  out  16  RUN cycles elapsed.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state IDLE, load_ready 0, imem_we 0, imem_waddr 0, imem_wdata 0, cpu_rst 1, busy 0, done 0, timeout 0, words_loaded 0, run_cycles 0. Address and hold counters 0.
- States are IDLE, LOAD, FILL, RST_HOLD, RUN, DONE.
- cpu_rst is 0 only in RUN. busy is 1 in LOAD, FILL, RST_HOLD and RUN.
- IDLE/DONE + start:
  - Go to LOAD.
  - Clear addr, words_loaded, run_cycles, done and timeout.
  - start in any other state is ignored.
- LOAD:
  - load_ready=1.
  - Accept on load_valid&load_ready. imem_we, imem_waddr=addr and imem_wdata=load_data are combinational in the same cycle (zero latency).
  - On accept: addr++ and words_loaded++.
  - Accept with addr==IMEM_DEPTH-1 → RST_HOLD. This takes priority; no fill is needed and load_last is irrelevant.
  - Accept with load_last=1 (addr<IMEM_DEPTH-1) → FILL.
  - No accept → no write, stay.
- FILL:
  - load_ready=0, imem_we=1, imem_wdata=32'h00000013 (NOP), imem_waddr=addr, addr++ each cycle.
  - After writing addr IMEM_DEPTH-1 → RST_HOLD.
- RST_HOLD: imem_we=0, cpu_rst=1 for exactly RST_HOLD cycles, then RUN.
- RUN:
  - cpu_rst=0, and run_cycles increments every cycle. Its value is the count including the current cycle, saturating at 16'hFFFF.
  - cpu_instr==32'h0000006f (jal x0,0) → DONE with done=1, timeout=0.
  - Otherwise, when run_cycles reaches RUN_CYCLES → DONE with done=1, timeout=1.
  - If halt and budget coincide in the same cycle, halt wins (timeout=0).
- DONE: cpu_rst=1, flags and counters frozen until start or rst.
- Reset mid-operation (any state): immediately IDLE with reset values. Partially written imem contents are left as-is.
- The stream side sees load_ready=0 outside LOAD. Words offered after a full 64-word load are never accepted.

Decomposition:
- Shared header/package cpu_defs:
  - state encoding localparams.
  - NOP_WORD = 32'h00000013.
  - HALT_WORD = 32'h0000006f.
  - Opcode constants already used by cpu_top.
- One sub-module, boot_run_watchdog:
  - RUN cycle counter, budget compare and halt detect.
  - Inputs: clk, rst, clr, en, cpu_instr.
  - Outputs: run_cycles, halt_hit, budget_hit.
- Everything else stays in imem_boot_ctrl.

Test Plan:
1. start, then 3 words (0x00a00093, 0x00300113, 0x002081b3) with load_last on the 3rd, valid every cycle:
   - Writes to addr 0..2 in 3 consecutive cycles, then 61 NOP writes to addr 3..63.
   - words_loaded=3, cpu_rst high 2 more cycles, then falls.
2. Backpressure gaps: load_valid toggles 1,0,0,1,1 → imem_we only on valid cycles, addresses contiguous 0,1,2, no write in gap cycles.
3. Halt after load: cpu_instr driven to 0x0000006f on 5th RUN cycle → done=1, timeout=0, run_cycles=5, cpu_rst=1 next cycle.
4. Timeout: cpu_instr never 0x0000006f → done=1, timeout=1, run_cycles=70 after 70 RUN cycles.
5. Full load: 64 words, load_last never asserted → no FILL writes, load_ready=0 after the 64th accept, 65th word stays pending, words_loaded=64.
6. rst pulsed mid-LOAD at addr 10 → same-cycle IDLE, cpu_rst=1, load_ready=0, counters 0; a following start reloads from addr 0.
